// File: rtl/alu16_reg_pkg.sv
// ============================================================================
// Module      : wisc_alu_pkg
// Description : Shared opcode constants and datapath width for the WISC-F24
//               execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wisc_alu_pkg;

  localparam int OPERAND_WIDTH  = 16;
  localparam int NUM_OPERATIONS = 4;

  // Oper encodings. SLBI, BTR and ROR also alias with Oper[2]=1.
  localparam logic [3:0] OP_ROL  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRA  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLBI = 4'b1000;
  localparam logic [3:0] OP_BTR  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;

endpackage

`default_nettype wire

// File: rtl/alu16_reg_if.sv
// ============================================================================
// Module      : alu16_reg_if
// Description : Operand/control bundle from decode into the registered ALU and
//               the registered result/flags back out.
//   master : drives en, InA, InB, Cin, Oper, invA, invB, sign
//   slave  : drives Out, Zero, Ofl, Cout, signFlag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu16_reg_if;
  import wisc_alu_pkg::*;

  logic                      en;
  logic [OPERAND_WIDTH-1:0]  InA;
  logic [OPERAND_WIDTH-1:0]  InB;
  logic                      Cin;
  logic [NUM_OPERATIONS-1:0] Oper;
  logic                      invA;
  logic                      invB;
  logic                      sign;
  logic [OPERAND_WIDTH-1:0]  Out;
  logic                      Zero;
  logic                      Ofl;
  logic                      Cout;
  logic                      signFlag;

  modport master (
    output en, InA, InB, Cin, Oper, invA, invB, sign,
    input  Out, Zero, Ofl, Cout, signFlag
  );

  modport slave (
    input  en, InA, InB, Cin, Oper, invA, invB, sign,
    output Out, Zero, Ofl, Cout, signFlag
  );

endinterface

`default_nettype wire

// File: rtl/alu16_reg_cla.sv
// ============================================================================
// Module      : cla_16b
// Description : 16-bit adder built from four 4-bit carry-lookahead blocks with
//               block-level generate/propagate chaining.
//   a, b   : addends
//   c_in   : carry into bit 0
//   sign   : 1 = two's-complement overflow rule, 0 = unsigned (ofl = c_out)
//   sum    : a + b + c_in modulo 2^16
//   c_out  : carry out of bit 15
//   ofl    : overflow under the selected rule
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_16b (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        c_in,
  input  wire logic        sign,
  output logic      [15:0] sum,
  output logic             c_out,
  output logic             ofl
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;       // carry into each bit
  logic [4:0]  w_blk_c;   // carry into each 4-bit block, [4] is the final carry
  logic [3:0]  w_blk_g;
  logic [3:0]  w_blk_p;

  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_blk_c[0] = c_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_block
    localparam int B = gi * 4;

    // Flattened lookahead equations inside the block.
    assign w_c[B]   = w_blk_c[gi];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_blk_c[gi]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                    | (w_p[B+1] & w_p[B] & w_blk_c[gi]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                    | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_blk_c[gi]);

    assign w_blk_g[gi] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                       | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_blk_p[gi] = &w_p[B+3:B];

    assign w_blk_c[gi+1] = w_blk_g[gi] | (w_blk_p[gi] & w_blk_c[gi]);
  end

  assign sum   = w_p ^ w_c;
  assign c_out = w_blk_c[4];
  assign ofl   = sign ? ((a[15] == b[15]) && (sum[15] != a[15])) : c_out;

endmodule

`default_nettype wire

// File: rtl/alu16_reg.sv
// ============================================================================
// Module      : alu16_reg
// Description : Registered 16-bit ALU for the execute stage. Operands may be
//               inverted, one of eleven operations is selected, and the result
//               plus zero/overflow/carry/sign flags are captured on an enabled
//               rising edge.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu16_reg_if (en, operands, controls in; result
//           and flags out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu16_reg
  import wisc_alu_pkg::*;
#(
  parameter int OPERAND_WIDTH  = wisc_alu_pkg::OPERAND_WIDTH,
  parameter int NUM_OPERATIONS = wisc_alu_pkg::NUM_OPERATIONS
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu16_reg_if.slave  bus
);

  logic [OPERAND_WIDTH-1:0]  w_a;
  logic [OPERAND_WIDTH-1:0]  w_b;
  logic [NUM_OPERATIONS-1:0] w_oper;
  logic [3:0]                w_sh;
  logic [4:0]                w_sh_inv;   // 16 - sh, used to wrap rotates
  logic [OPERAND_WIDTH-1:0]  w_sum;
  logic                      w_cout;
  logic                      w_ofl;
  logic [OPERAND_WIDTH-1:0]  w_rol;
  logic [OPERAND_WIDTH-1:0]  w_ror;
  logic [OPERAND_WIDTH-1:0]  w_sll;
  logic [OPERAND_WIDTH-1:0]  w_sra;
  logic [OPERAND_WIDTH-1:0]  w_srl;
  logic [OPERAND_WIDTH-1:0]  w_btr;
  logic [OPERAND_WIDTH-1:0]  w_result;

  logic [OPERAND_WIDTH-1:0]  r_out;
  logic                      r_zero;
  logic                      r_ofl;
  logic                      r_cout;
  logic                      r_sign_flag;

  assign w_a      = bus.invA ? ~bus.InA : bus.InA;
  assign w_b      = bus.invB ? ~bus.InB : bus.InB;
  assign w_oper   = bus.Oper;
  assign w_sh     = w_b[3:0];
  assign w_sh_inv = 5'd16 - {1'b0, w_sh};

  // The adder runs every cycle so carry/overflow are always meaningful.
  cla_16b u_cla (
    .a     (w_a),
    .b     (w_b),
    .c_in  (bus.Cin),
    .sign  (bus.sign),
    .sum   (w_sum),
    .c_out (w_cout),
    .ofl   (w_ofl)
  );

  // With sh=0 the wrap term shifts by 16, which yields zero and leaves A'.
  assign w_rol = (w_a << w_sh) | (w_a >> w_sh_inv);
  assign w_ror = (w_a >> w_sh) | (w_a << w_sh_inv);
  assign w_sll = w_a << w_sh;
  assign w_srl = w_a >> w_sh;
  assign w_sra = $unsigned($signed(w_a) >>> w_sh);

  always_comb begin
    w_btr = '0;
    for (int i = 0; i < OPERAND_WIDTH; i++) begin
      w_btr[i] = w_a[OPERAND_WIDTH-1-i];
    end
  end

  always_comb begin
    w_result = '0;
    if (w_oper[3]) begin
      // Oper[2] is a don't-care in the upper half of the opcode space.
      case (w_oper[1:0])
        2'b00:   w_result = {w_a[7:0], 8'h00};
        2'b01:   w_result = w_btr;
        default: w_result = w_ror;
      endcase
    end else begin
      case (w_oper)
        OP_ROL:  w_result = w_rol;
        OP_SLL:  w_result = w_sll;
        OP_SRA:  w_result = w_sra;
        OP_SRL:  w_result = w_srl;
        OP_ADD:  w_result = w_sum;
        OP_AND:  w_result = w_a & w_b;
        OP_OR:   w_result = w_a | w_b;
        OP_XOR:  w_result = w_a ^ w_b;
        default: w_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_zero      <= 1'b1;
      r_ofl       <= 1'b0;
      r_cout      <= 1'b0;
      r_sign_flag <= 1'b0;
    end else if (bus.en) begin
      r_out       <= w_result;
      r_zero      <= (w_result == '0);
      r_ofl       <= w_ofl;
      r_cout      <= w_cout;
      r_sign_flag <= w_result[OPERAND_WIDTH-1];
    end
  end

  assign bus.Out      = r_out;
  assign bus.Zero     = r_zero;
  assign bus.Ofl      = r_ofl;
  assign bus.Cout     = r_cout;
  assign bus.signFlag = r_sign_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu16_reg.sv
// ============================================================================
// Module      : tb_alu16_reg
// Description : Directed self-checking bench for alu16_reg with hand-computed
//               expected results and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu16_reg;
  import wisc_alu_pkg::*;

  logic clk;
  logic rst_n;
  logic clk_on;
  int   n_checks;
  int   n_errors;

  alu16_reg_if bus ();

  alu16_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic o,
                             input logic c, input logic s);
    check({tag, ".Zero"},     {15'd0, bus.Zero},     {15'd0, z});
    check({tag, ".Ofl"},      {15'd0, bus.Ofl},      {15'd0, o});
    check({tag, ".Cout"},     {15'd0, bus.Cout},     {15'd0, c});
    check({tag, ".signFlag"}, {15'd0, bus.signFlag}, {15'd0, s});
  endtask

  // Drive one operation on the falling edge, capture on the next rising edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] oper,
                       input logic ia, input logic ib, input logic sg);
    @(negedge clk);
    bus.en   = 1'b1;
    bus.InA  = a;
    bus.InB  = b;
    bus.Cin  = cin;
    bus.Oper = oper;
    bus.invA = ia;
    bus.invB = ib;
    bus.sign = sg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_on   = 1'b0;
    rst_n    = 1'b1;
    bus.en   = 1'b0;
    bus.InA  = 16'h1234;
    bus.InB  = 16'h0001;
    bus.Cin  = 1'b0;
    bus.Oper = OP_ADD;
    bus.invA = 1'b0;
    bus.invB = 1'b0;
    bus.sign = 1'b0;

    // Reset with no clock running.
    #2 rst_n = 1'b0;
    #1;
    check("rst.Out", bus.Out, 16'h0000);
    check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Release with en=0: outputs stay at reset values.
    #2 rst_n = 1'b1;
    clk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rel_hold.Out", bus.Out, 16'h0000);
    check("rel_hold.Zero", {15'd0, bus.Zero}, 16'd1);

    // Signed add overflow.
    do_op(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    check("add_s.Out", bus.Out, 16'h8000);
    check_flags("add_s", 1'b0, 1'b1, 1'b0, 1'b1);

    // Same sum under unsigned rules: no carry, so no overflow.
    do_op(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("add_u.Out", bus.Out, 16'h8000);
    check("add_u.Ofl", {15'd0, bus.Ofl}, 16'd0);

    // 5 - 5 via invB and Cin.
    do_op(16'h0005, 16'h0005, 1'b1, OP_ADD, 1'b0, 1'b1, 1'b1);
    check("sub.Out", bus.Out, 16'h0000);
    check_flags("sub", 1'b1, 1'b0, 1'b1, 1'b0);

    // Unsigned wrap: overflow follows carry.
    do_op(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("wrap.Out", bus.Out, 16'h0000);
    check_flags("wrap", 1'b1, 1'b1, 1'b1, 1'b0);

    // Adder flags still update on a non-add op; Zero follows the result.
    do_op(16'hFFFF, 16'h0001, 1'b0, OP_ROL, 1'b0, 1'b0, 1'b0);
    check("rolflag.Out", bus.Out, 16'hFFFF);
    check_flags("rolflag", 1'b0, 1'b1, 1'b1, 1'b1);

    // Rotates.
    do_op(16'h8001, 16'h0004, 1'b0, OP_ROL, 1'b0, 1'b0, 1'b0);
    check("rol4", bus.Out, 16'h0018);
    do_op(16'h8001, 16'h0004, 1'b0, OP_ROR, 1'b0, 1'b0, 1'b0);
    check("ror4", bus.Out, 16'h1800);
    do_op(16'h8001, 16'h0004, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("ror4_alias", bus.Out, 16'h1800);
    do_op(16'h8001, 16'h0010, 1'b0, OP_ROL, 1'b0, 1'b0, 1'b0);
    check("rol0", bus.Out, 16'h8001);
    do_op(16'h8001, 16'h0010, 1'b0, OP_ROR, 1'b0, 1'b0, 1'b0);
    check("ror0", bus.Out, 16'h8001);
    do_op(16'h8001, 16'h000F, 1'b0, OP_ROL, 1'b0, 1'b0, 1'b0);
    check("rol15", bus.Out, 16'hC000);

    // Shifts.
    do_op(16'h8000, 16'h0003, 1'b0, OP_SRA, 1'b0, 1'b0, 1'b0);
    check("sra3", bus.Out, 16'hF000);
    do_op(16'h8000, 16'h0003, 1'b0, OP_SRL, 1'b0, 1'b0, 1'b0);
    check("srl3", bus.Out, 16'h1000);
    do_op(16'h0001, 16'h000F, 1'b0, OP_SLL, 1'b0, 1'b0, 1'b0);
    check("sll15", bus.Out, 16'h8000);
    check("sll15.signFlag", {15'd0, bus.signFlag}, 16'd1);

    // Logic ops.
    do_op(16'hF0F0, 16'hFF00, 1'b0, OP_AND, 1'b0, 1'b0, 1'b0);
    check("and", bus.Out, 16'hF000);
    do_op(16'hF0F0, 16'hFF00, 1'b0, OP_OR, 1'b0, 1'b0, 1'b0);
    check("or", bus.Out, 16'hFFF0);
    do_op(16'hF0F0, 16'hFF00, 1'b0, OP_XOR, 1'b0, 1'b0, 1'b0);
    check("xor", bus.Out, 16'h0FF0);

    // SLBI, BTR, with aliases and operand inversion.
    do_op(16'h12AB, 16'h0000, 1'b0, OP_SLBI, 1'b0, 1'b0, 1'b0);
    check("slbi", bus.Out, 16'hAB00);
    do_op(16'h12AB, 16'h0000, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
    check("slbi_alias", bus.Out, 16'hAB00);
    do_op(16'h0001, 16'h0000, 1'b0, OP_BTR, 1'b0, 1'b0, 1'b0);
    check("btr", bus.Out, 16'h8000);
    do_op(16'h0001, 16'h0000, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    check("btr_inv", bus.Out, 16'h7FFF);
    check("btr_inv.signFlag", {15'd0, bus.signFlag}, 16'd0);

    // Hold: inputs change with en=0.
    @(negedge clk);
    bus.en   = 1'b0;
    bus.InA  = 16'hFFFF;
    bus.InB  = 16'h0001;
    bus.Oper = OP_ADD;
    bus.invA = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold.Out", bus.Out, 16'h7FFF);
      check("hold.Cout", {15'd0, bus.Cout}, 16'd0);
    end

    // Mid-stream async reset clears immediately and discards the result.
    do_op(16'h1234, 16'h0000, 1'b0, OP_OR, 1'b0, 1'b0, 1'b0);
    check("pre_rst", bus.Out, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.Out", bus.Out, 16'h0000);
    check_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_hold", bus.Out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu16_reg.md
# alu16_reg

16-bit registered ALU for the WISC-F24 execute stage. It conditionally inverts both operands, then computes one of eleven operations: rotate, shift, add, logic, SLBI shift, bit-reverse or rotate-right. All results and status flags (zero, overflow, carry, sign) are captured in an output register. Decode drives `Oper`, `invA`, `invB`, `Cin` and `sign`; branch/flag logic consumes the registered flags.

## Interface
- `OPERAND_WIDTH`, 16, datapath width; only 16 is supported.
- `NUM_OPERATIONS`, 4, width of `Oper`.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: capture enable; 0 holds all outputs.
- `InA` input 16: operand A.
- `InB` input 16: operand B; bits [3:0] are the shift/rotate amount.
- `Cin` input 1: adder carry-in.
- `Oper` input 4: operation select.
- `invA` input 1: use ~InA in place of InA.
- `invB` input 1: use ~InB in place of InB.
- `sign` input 1: 1 selects signed overflow rules, 0 selects unsigned.
- `Out` output 16: registered result.
- `Zero` output 1: registered, equals (Out == 0).
- `Ofl` output 1: registered adder overflow.
- `Cout` output 1: registered adder carry-out.
- `signFlag` output 1: registered, equals Out[15].

## Operation
- Operand preparation:
  - A' = invA ? ~InA : InA.
  - B' = invB ? ~InB : InB.
  - Inversion applies to every operation.
- Amount for all shifts and rotates: sh = B'[3:0], range 0–15; sh = 0 passes A' unchanged.
- Results by `Oper`:
  - 0000 rotate left A' by sh.
  - 0001 shift left logical, zero-fill.
  - 0010 shift right arithmetic, A'[15] fill.
  - 0011 shift right logical, zero-fill.
  - 0100 A' + B' + Cin, modulo 2^16.
  - 0101 A' & B'.
  - 0110 A' | B'.
  - 0111 A' ^ B'.
  - 1000 and 1100: A' << 8, low byte zero.
  - 1001 and 1101: bit-reverse, result[i] = A'[15−i].
  - 1010, 1011, 1110, 1111: rotate right A' by sh.
  - For `Oper[3]=1`, `Oper[2]` is ignored.
- Adder flags are computed every cycle regardless of `Oper`:
  - `Cout` = carry out of bit 15.
  - `Ofl` when sign=1: A'[15]==B'[15] and sum[15]!=A'[15].
  - `Ofl` when sign=0: equals `Cout`.
- `Zero` and `signFlag` derive from the selected result, not from the adder sum.
- No simulation-only output (e.g. $display) in synthesizable RTL.

## Timing
- Combinational result path; one register stage.
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- en=0 at an edge: all outputs hold their previous values.
- rst_n low: immediately forces Out=0, Zero=1, Ofl=0, Cout=0, signFlag=0. These hold until the first enabled edge after release.
- Reset asserted mid-stream discards the in-flight result.
- Throughput is one operation per cycle; there is no handshake beyond `en`.

## Structure
- Shared package `wisc_alu_pkg` holds:
  - the 4-bit opcode constants (ROL, SLL, SRA, SRL, ADD, AND, OR, XOR, SLBI, BTR, ROR);
  - `OPERAND_WIDTH`.
- Natural sub-module: `cla_16b`, a 4×4-bit carry-lookahead adder with `sum`, `c_out`, `ofl`, `sign` ports.
- Existing `rotater` (rotate right) and `quadmux4_1` (4-bit 4:1 mux) are reused for the rotate-right path and the ADD/AND/OR/XOR select.
- Left/right shifter is inline or the existing `shifter`.

## Test plan
- Reset:
  - rst_n=0 with no clock → Out=0x0000, Zero=1, Ofl=0, Cout=0, signFlag=0.
  - Release with en=0 → outputs unchanged.
- Signed add:
  - A=0x7FFF, B=0x0001, Cin=0, sign=1, Oper=0100 → next cycle Out=0x8000, Ofl=1, Cout=0, signFlag=1, Zero=0.
  - Same inputs with sign=0 → Ofl=0.
- Subtract via invert:
  - A=0x0005, B=0x0005, invB=1, Cin=1, Oper=0100 → Out=0x0000, Zero=1, Cout=1, Ofl=0.
  - A=0xFFFF, B=0x0001, sign=0, Oper=0100 → Out=0x0000, Cout=1, Ofl=1.
- Rotates:
  - A=0x8001, B=0x0004: Oper=0000 → 0x0018; Oper=1010 → 0x1800; Oper=1111 → 0x1800.
  - B=0x0010 (sh=0) → 0x8001.
- Shifts:
  - A=0x8000, B=0x0003: Oper=0010 → 0xF000; Oper=0011 → 0x1000.
  - A=0x0001, B=0x000F, Oper=0001 → 0x8000.
- SLBI, BTR and hold:
  - A=0x12AB, Oper=1000 → 0xAB00.
  - A=0x0001, Oper=1001 → 0x8000.
  - A=0x0001, invA=1, Oper=1101 → 0x7FFF.
  - Change inputs with en=0 → outputs hold for 3 cycles.
